alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Stage directly downstream of the ALU; commits its result and condition flags.
//  Holds the architectural flag register; flags_carry feeds the ALU carry_in.
//  Queues register-file writes in a small FIFO with valid/ready on both sides,
//  so a busy register-file write port back-pressures the ALU.
// PARAMETERS
//  DEPTH        2  write-queue entries; legal values 2 or 4 only
//  REG_INDEX_W  4  width of a register-file index
// PORTS
//  clock        in   1        single clock, rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  in_valid     in   1        ALU result presented this cycle
//  in_ready     out  1        stage can accept (count != DEPTH)
//  in_result    in   t_reg    ALU result (32b)
//  in_flags     in   t_flags  {carry,zero,neg,over} from ALU
//  in_flags_en  in   1        accept updates the flag register
//  in_write_en  in   1        accept enqueues a register write
//  in_index     in   REG_INDEX_W  destination register
//  wb_valid     out  1        head entry valid
//  wb_ready     in   1        register file takes head this cycle
//  wb_index     out  REG_INDEX_W  head destination; 0 when empty
//  wb_data      out  t_reg    head data; 0 when empty
//  flags        out  t_flags  architectural flags (flags.carry -> ALU carry_in)
//  count        out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset (async, reset_n=0): count=0, all entries cleared, wb_valid=0,
//   wb_index=0, wb_data=0, flags=4'b0000, in_ready=1 after deassertion.
//  Accept = in_valid & in_ready. Pop = wb_valid & wb_ready.
//  in_ready = (count != DEPTH); it does not depend on wb_ready (no full bypass).
//  Accept with in_write_en=1 enqueues {in_index,in_result} at tail.
//  Accept with in_write_en=0 (COMP/BIT/TEST) enqueues nothing.
//  Accept with in_flags_en=1 loads flags from in_flags on that clock edge.
//   The next cycle's ALU op therefore sees the new carry.
//  Accept with in_flags_en=0 leaves flags unchanged.
//  Latency: entry visible on wb_* the cycle after accept; no same-cycle pass-through.
//  wb_* are driven from the head register, never combinationally from in_*.
//  Simultaneous push+pop with 0<count<DEPTH: count unchanged, order preserved.
//  Push+pop when full cannot occur (in_ready=0); a pop when full frees one slot next cycle.
//  Pop when empty is impossible (wb_valid=0); wb_ready is ignored then.
//  Pointers wrap modulo DEPTH; count saturates by construction (0..DEPTH).
//  Reset mid-operation discards all queued writes; flags return to 0.
//  X on in_* with in_valid=0 must not disturb state.
// CONFIGURATION
//  WB_FORWARD_EN defined: adds the following ports.
//   fwd_index  in   REG_INDEX_W  register being read
//   fwd_hit    out  1            a queued entry targets fwd_index
//   fwd_data   out  t_reg        data of the youngest matching entry
//   fwd_* are combinational from queue state only; an entry popping this
//    cycle still counts as a hit.
//  WB_FORWARD_EN undefined: ports absent, no compare logic.
// STRUCTURE
//  alu.vh: add typedef t_flags (packed struct carry, zero, neg, over).
//  registers.vh: t_reg, t_reg_index (REG_INDEX_W wide).
//  Sub-module wb_queue: generic DEPTH-entry FIFO
//   (push/pop/head/count, plus per-entry view for forwarding).
//  alu_writeback: flag register, accept/enqueue control, forward compare.
// TESTING
//  Reset: reset_n=0 mid-traffic -> count=0, wb_valid=0, flags=0 asynchronously.
//  Single write: accept idx=3, data=32'h0000_00FF, wb_ready=1
//   -> wb_valid next cycle, idx 3, data FF, popped, count back to 0.
//  Full: wb_ready=0, accept 2 writes (DEPTH=2) -> in_ready=0;
//   third in_valid held -> not accepted; wb_ready=1 -> order 1,2,3 preserved.
//  Flags: COMP accept, write_en=0, flags_en=1, in_flags=4'b0110
//   -> flags=0110 next cycle, count unchanged; flags_en=0 accept -> flags held.
//  Carry chain: ADD sets carry=1, then ADDC accepted the following cycle
//   -> flags.carry=1 presented to the ALU in that cycle.
//  Forward (WB_FORWARD_EN): queue idx5=AAAA then idx5=BBBB, fwd_index=5
//   -> fwd_hit=1, fwd_data=BBBB; fwd_index=6 -> fwd_hit=0.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback stage: register data, register index and the condition-flag word.
// Flag bit order is {carry, zero, neg, over}, with carry in the MSB.
package alu_writeback_pkg;

   localparam int REG_W       = 32;
   localparam int REG_INDEX_W = 4;

   typedef logic [REG_W-1:0]       t_reg;
   typedef logic [REG_INDEX_W-1:0] t_reg_index;

   typedef struct packed {
      logic carry;
      logic zero;
      logic neg;
      logic over;
   } t_flags;

   localparam t_flags FLAGS_CLEAR = '{carry: 1'b0, zero: 1'b0, neg: 1'b0, over: 1'b0};

endpackage

// File: rtl/alu_writeback_wb_queue.sv
// wb_queue: DEPTH-entry FIFO of {index, data} register-file writes, with a head view and an
// optional age-ordered entry view (oldest first) used for forwarding when WB_FORWARD_EN is defined.
module wb_queue
   import alu_writeback_pkg::*;
#(
   parameter  int DEPTH = 2,
   parameter  int IDX_W = REG_INDEX_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [IDX_W-1:0] push_index,
   input  logic [31:0]      push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [IDX_W-1:0] head_index,
   output logic [31:0]      head_data,
   output logic [CNT_W-1:0] count
`ifdef WB_FORWARD_EN
   ,
   output logic [DEPTH-1:0]            view_vld,
   output logic [DEPTH-1:0][IDX_W-1:0] view_index,
   output logic [DEPTH-1:0][31:0]      view_data
`endif
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [IDX_W-1:0] mem_index [DEPTH];
   t_reg             mem_data  [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & (cnt != FULL);
   assign pop_ok  = pop & (cnt != '0);

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_index[i] <= '0;
            mem_data[i]  <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_index[wr_ptr] <= push_index;
            mem_data[wr_ptr]  <= push_data;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         // Popped slots are zeroed so an empty queue presents zero on the head outputs.
         if (pop_ok) begin
            mem_index[rd_ptr] <= '0;
            mem_data[rd_ptr]  <= '0;
            rd_ptr            <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign head_valid = (cnt != '0);
   assign head_index = mem_index[rd_ptr];
   assign head_data  = mem_data[rd_ptr];
   assign count      = cnt;

`ifdef WB_FORWARD_EN
   always_comb begin
      view_vld   = '0;
      view_index = '0;
      view_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         view_vld[i]   = (CNT_W'(i) < cnt);
         view_index[i] = mem_index[rd_ptr + PTR_W'(i)];
         view_data[i]  = mem_data[rd_ptr + PTR_W'(i)];
      end
   end
`endif

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: commits ALU results into a write queue and holds the architectural flag register.
// Optional macro WB_FORWARD_EN adds fwd_index/fwd_hit/fwd_data lookup into the queued writes.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter  int DEPTH       = 2,
   parameter  int REG_INDEX_W = alu_writeback_pkg::REG_INDEX_W,
   localparam int CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_result,
   input  logic [3:0]             in_flags,
   input  logic                   in_flags_en,
   input  logic                   in_write_en,
   input  logic [REG_INDEX_W-1:0] in_index,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [REG_INDEX_W-1:0] wb_index,
   output logic [31:0]            wb_data,
   output logic [3:0]             flags,
   output logic [CNT_W-1:0]       count
`ifdef WB_FORWARD_EN
   ,
   input  logic [REG_INDEX_W-1:0] fwd_index,
   output logic                   fwd_hit,
   output logic [31:0]            fwd_data
`endif
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   function automatic t_flags flags_next(input t_flags cur, input logic [3:0] upd, input logic load);
      return load ? t_flags'(upd) : cur;
   endfunction

   logic       accept_p0;
   logic       push_p0;
   logic       pop_p0;
   t_flags     flags_d;
   t_flags     flags_p1;
   logic [CNT_W-1:0] q_count;

`ifdef WB_FORWARD_EN
   logic [DEPTH-1:0]                  view_vld;
   logic [DEPTH-1:0][REG_INDEX_W-1:0] view_index;
   logic [DEPTH-1:0][31:0]            view_data;
`endif

   // Acceptance stage: in_ready depends only on occupancy, never on wb_ready.
   assign in_ready  = (q_count != FULL);
   assign accept_p0 = in_valid & in_ready;
   assign push_p0   = accept_p0 & in_write_en;
   assign pop_p0    = wb_valid & wb_ready;
   assign flags_d   = flags_next(flags_p1, in_flags, accept_p0 & in_flags_en);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flags_p1 <= FLAGS_CLEAR;
      end else begin
         flags_p1 <= flags_d;
      end
   end

   assign flags = flags_p1;
   assign count = q_count;

   // Commit stage: register-file writes leave from the queue head only.
   wb_queue #(
      .DEPTH (DEPTH),
      .IDX_W (REG_INDEX_W)
   ) u_queue (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (push_p0),
      .push_index (in_index),
      .push_data  (in_result),
      .pop        (pop_p0),
      .head_valid (wb_valid),
      .head_index (wb_index),
      .head_data  (wb_data),
      .count      (q_count)
`ifdef WB_FORWARD_EN
      ,
      .view_vld   (view_vld),
      .view_index (view_index),
      .view_data  (view_data)
`endif
   );

`ifdef WB_FORWARD_EN
   // View is oldest-first, so the last match scanned is the youngest write to that register.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (view_vld[i] && (view_index[i] == fwd_index)) begin
            fwd_hit  = 1'b1;
            fwd_data = view_data[i];
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback (DEPTH=2): reset, single write, full queue, flags, carry chain,
// idle X inputs, asynchronous reset mid-traffic, and forwarding when WB_FORWARD_EN is defined.
module tb_alu_writeback;

   localparam int DEPTH = 2;
   localparam int IW    = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_result;
   logic [3:0]    in_flags;
   logic          in_flags_en;
   logic          in_write_en;
   logic [IW-1:0] in_index;
   logic          wb_valid;
   logic          wb_ready;
   logic [IW-1:0] wb_index;
   logic [31:0]   wb_data;
   logic [3:0]    flags;
   logic [CW-1:0] count;
`ifdef WB_FORWARD_EN
   logic [IW-1:0] fwd_index;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
`endif

   int err_cnt = 0;
   int chk_cnt = 0;

   alu_writeback #(
      .DEPTH       (DEPTH),
      .REG_INDEX_W (IW)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_flags    (in_flags),
      .in_flags_en (in_flags_en),
      .in_write_en (in_write_en),
      .in_index    (in_index),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_index    (wb_index),
      .wb_data     (wb_data),
      .flags       (flags),
      .count       (count)
`ifdef WB_FORWARD_EN
      ,
      .fwd_index   (fwd_index),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic fe, input logic [IW-1:0] idx,
                        input logic [31:0] res, input logic [3:0] fl);
      in_valid    = v;
      in_write_en = we;
      in_flags_en = fe;
      in_index    = idx;
      in_result   = res;
      in_flags    = fl;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n  = 1'b1;
      wb_ready = 1'b0;
`ifdef WB_FORWARD_EN
      fwd_index = '0;
`endif
      idle();
      #2 reset_n = 1'b0;
      step();
      step();
      check("rst_count", 32'(count), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_index", 32'(wb_index), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      reset_n = 1'b1;
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // single write, popped straight away
      wb_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h0000_00FF, 4'b0000);
      step();
      idle();
      check("single_valid", 32'(wb_valid), 32'd1);
      check("single_index", 32'(wb_index), 32'd3);
      check("single_data", wb_data, 32'h0000_00FF);
      check("single_count", 32'(count), 32'd1);
      step();
      check("single_drained", 32'(count), 32'd0);
      check("single_empty_valid", 32'(wb_valid), 32'd0);
      check("single_empty_data", wb_data, 32'd0);

      // full queue, back-pressure, order preserved
      wb_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h11, 4'b0000);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h22, 4'b0000);
      step();
      check("full_count", 32'(count), 32'd2);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_head_index", 32'(wb_index), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h33, 4'b0000);
      step();
      check("full_hold_count", 32'(count), 32'd2);
      check("full_hold_data", wb_data, 32'h11);
      wb_ready = 1'b1;
      step();
      check("order_2_data", wb_data, 32'h22);
      check("order_2_index", 32'(wb_index), 32'd2);
      check("order_2_count", 32'(count), 32'd1);
      check("order_2_ready", 32'(in_ready), 32'd1);
      step();
      idle();
      check("order_3_data", wb_data, 32'h33);
      check("order_3_count", 32'(count), 32'd1);
      step();
      check("order_empty", 32'(wb_valid), 32'd0);

      // flags: COMP-style accept then a hold with flags_en=0
      drive(1'b1, 1'b0, 1'b1, 4'd9, 32'hDEAD_BEEF, 4'b0110);
      step();
      idle();
      check("flags_load", 32'(flags), 32'h6);
      check("flags_no_enqueue", 32'(count), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 4'd9, 32'h0, 4'b1111);
      step();
      idle();
      check("flags_hold", 32'(flags), 32'h6);

      // carry chain: ADD sets carry, ADDC the next cycle sees it
      drive(1'b1, 1'b1, 1'b1, 4'd4, 32'd5, 4'b1000);
      step();
      drive(1'b1, 1'b1, 1'b1, 4'd4, 32'd6, 4'b0001);
      check("carry_to_addc", 32'(flags[3]), 32'd1);
      step();
      idle();
      check("carry_after_addc", 32'(flags), 32'h1);
      check("carry_q_data", wb_data, 32'd6);
      check("carry_q_count", 32'(count), 32'd1);
      step();
      check("carry_drained", 32'(count), 32'd0);

      // unknown inputs while idle leave state alone
      wb_ready    = 1'b0;
      in_valid    = 1'b0;
      in_write_en = 1'bx;
      in_flags_en = 1'bx;
      in_index    = 'x;
      in_result   = 'x;
      in_flags    = 'x;
      step();
      step();
      check("x_count", 32'(count), 32'd0);
      check("x_flags", 32'(flags), 32'h1);
      check("x_wb_valid", 32'(wb_valid), 32'd0);

      // asynchronous reset in the middle of traffic
      drive(1'b1, 1'b1, 1'b1, 4'd7, 32'h77, 4'b1010);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd8, 32'h88, 4'b0000);
      step();
      idle();
      check("pre_rst_count", 32'(count), 32'd2);
      check("pre_rst_flags", 32'(flags), 32'hA);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_valid", 32'(wb_valid), 32'd0);
      check("async_rst_data", wb_data, 32'd0);
      check("async_rst_flags", 32'(flags), 32'd0);
      step();
      reset_n = 1'b1;
      step();
      check("post_rst_ready", 32'(in_ready), 32'd1);
      check("post_rst_count", 32'(count), 32'd0);

`ifdef WB_FORWARD_EN
      // forwarding picks the youngest matching entry
      wb_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_AAAA, 4'b0000);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_BBBB, 4'b0000);
      step();
      idle();
      fwd_index = 4'd5;
      #1;
      check("fwd_hit5", 32'(fwd_hit), 32'd1);
      check("fwd_data5", fwd_data, 32'h0000_BBBB);
      fwd_index = 4'd6;
      #1;
      check("fwd_miss6", 32'(fwd_hit), 32'd0);
      step();
      wb_ready  = 1'b1;
      step();
      fwd_index = 4'd5;
      #1;
      check("fwd_popping_hit", 32'(fwd_hit), 32'd1);
      check("fwd_popping_data", fwd_data, 32'h0000_BBBB);
      step();
      check("fwd_drained_hit", 32'(fwd_hit), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
